// File: rtl/control_unit_pkg.sv
// Shared instruction-set definitions: opcodes, field positions, ALU select codes and FSM states.
package control_unit_pkg;

    localparam int OP_MSB   = 15;
    localparam int OP_LSB   = 12;
    localparam int REG_MSB  = 11;
    localparam int REG_LSB  = 8;
    localparam int ADDR_MSB = 7;
    localparam int ADDR_LSB = 0;
    localparam int RA_MSB   = 7;
    localparam int RA_LSB   = 4;
    localparam int RB_MSB   = 3;
    localparam int RB_LSB   = 0;

    localparam logic [3:0] OP_NOP   = 4'b0000;
    localparam logic [3:0] OP_LOAD  = 4'b0001;
    localparam logic [3:0] OP_STORE = 4'b0010;
    localparam logic [3:0] OP_HALT  = 4'b0011;

    typedef enum logic [3:0] {
        A_ADD = 4'd0,
        A_SUB = 4'd1,
        A_AND = 4'd2,
        A_OR  = 4'd3,
        A_XOR = 4'd4,
        A_NOT = 4'd5,
        A_SHL = 4'd6,
        A_SHR = 4'd7
    } alu_sel_e;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        LOAD1,
        LOAD2,
        STORE,
        ALU,
        HALTED
    } state_e;

    // Opcodes with the top bit set are ALU operations; 01xx is reserved and behaves as NOP.
    function automatic state_e decode_next(input logic [3:0] op);
        if (op[3]) return ALU;
        case (op)
            OP_LOAD:  return LOAD1;
            OP_STORE: return STORE;
            OP_HALT:  return HALTED;
            default:  return FETCH;
        endcase
    endfunction

    function automatic alu_sel_e alu_sel_of(input logic [2:0] func);
        return alu_sel_e'({1'b0, func});
    endfunction

endpackage

// File: rtl/control_unit.sv
// Multi-cycle control FSM: fetches from the instruction ROM, decodes and sequences the datapath.
module control_unit
    import control_unit_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int D_ADDR_W = 8,
    parameter int R_ADDR_W = 4,
    parameter int I_ADDR_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [WIDTH-1:0]    I_data,
    output logic [I_ADDR_W-1:0] I_addr,
    output logic [D_ADDR_W-1:0] D_addr,
    output logic [R_ADDR_W-1:0] RF_W_addr,
    output logic [R_ADDR_W-1:0] RF_A_addr,
    output logic [R_ADDR_W-1:0] RF_B_addr,
    output logic                D_wr,
    output logic                RF_s,
    output logic                RF_W_en,
    output logic [3:0]          ALU_sel,
    output logic                busy,
    output logic                halted
);

    state_e              state_q, state_d;
    logic [I_ADDR_W-1:0] pc_q, pc_d;
    logic [WIDTH-1:0]    ir_q, ir_d;

    // NOTE: every next-state value gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        case (state_q)
            IDLE, HALTED: begin
                if (start) begin
                    pc_d    = '0;
                    state_d = FETCH;
                end
            end
            FETCH:  state_d = DECODE;
            DECODE: begin
                ir_d    = I_data;
                pc_d    = pc_q + 1'b1;
                state_d = decode_next(I_data[OP_MSB:OP_LSB]);
            end
            LOAD1:  state_d = LOAD2;
            default: state_d = FETCH;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pc_q    <= '0;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end

    // Datapath controls depend only on state and IR, so reset forces them all to zero at once.
    always_comb begin
        I_addr    = '0;
        D_addr    = '0;
        RF_W_addr = '0;
        RF_A_addr = '0;
        RF_B_addr = '0;
        D_wr      = 1'b0;
        RF_s      = 1'b0;
        RF_W_en   = 1'b0;
        ALU_sel   = '0;
        case (state_q)
            FETCH: I_addr = pc_q;
            LOAD1: begin
                D_addr = D_ADDR_W'(ir_q[ADDR_MSB:ADDR_LSB]);
                RF_s   = 1'b1;
            end
            LOAD2: begin
                D_addr    = D_ADDR_W'(ir_q[ADDR_MSB:ADDR_LSB]);
                RF_s      = 1'b1;
                RF_W_en   = 1'b1;
                RF_W_addr = R_ADDR_W'(ir_q[REG_MSB:REG_LSB]);
            end
            STORE: begin
                D_wr      = 1'b1;
                D_addr    = D_ADDR_W'(ir_q[ADDR_MSB:ADDR_LSB]);
                RF_A_addr = R_ADDR_W'(ir_q[REG_MSB:REG_LSB]);
            end
            ALU: begin
                RF_W_en   = 1'b1;
                ALU_sel   = alu_sel_of(ir_q[OP_MSB-1:OP_LSB]);
                RF_W_addr = R_ADDR_W'(ir_q[REG_MSB:REG_LSB]);
                RF_A_addr = R_ADDR_W'(ir_q[RA_MSB:RA_LSB]);
                RF_B_addr = R_ADDR_W'(ir_q[RB_MSB:RB_LSB]);
            end
            default: ;
        endcase
    end

    assign busy   = (state_q != IDLE) && (state_q != HALTED);
    assign halted = (state_q == HALTED);

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench: per-cycle output trace compared against an instruction-level reference model.
module tb_control_unit;
    import control_unit_pkg::*;

    typedef struct packed {
        logic [7:0] i_addr;
        logic [7:0] d_addr;
        logic [3:0] w_addr;
        logic [3:0] a_addr;
        logic [3:0] b_addr;
        logic       d_wr;
        logic       rf_s;
        logic       w_en;
        logic [3:0] alu_sel;
        logic       busy;
        logic       halted;
    } out_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] I_data = '0;
    logic [7:0]  I_addr, D_addr;
    logic [3:0]  RF_W_addr, RF_A_addr, RF_B_addr, ALU_sel;
    logic        D_wr, RF_s, RF_W_en, busy, halted;

    logic [15:0] rom [256];
    out_t        exp_q [$];
    out_t        obs;
    int          errors = 0;
    int          checks = 0;

    control_unit dut (
        .clk(clk), .rst_n(rst_n), .start(start), .I_data(I_data),
        .I_addr(I_addr), .D_addr(D_addr),
        .RF_W_addr(RF_W_addr), .RF_A_addr(RF_A_addr), .RF_B_addr(RF_B_addr),
        .D_wr(D_wr), .RF_s(RF_s), .RF_W_en(RF_W_en), .ALU_sel(ALU_sel),
        .busy(busy), .halted(halted)
    );

    always #5 clk = ~clk;

    // Synchronous instruction ROM: data valid one cycle after the address.
    always @(posedge clk) I_data <= rom[I_addr];

    always_comb obs = {I_addr, D_addr, RF_W_addr, RF_A_addr, RF_B_addr,
                       D_wr, RF_s, RF_W_en, ALU_sel, busy, halted};

    task automatic check_out(input string tag, input out_t o, input out_t e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    task automatic check_val(input string tag, input logic [31:0] o, input logic [31:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, o, e);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Reference model: executes the program instruction by instruction and lists the
    // externally visible controls of every cycle each instruction occupies.
    task automatic build_trace(input int max_instr);
        int   pc;
        out_t r;
        logic [15:0] ins;
        logic [3:0]  op;
        exp_q.delete();
        pc = 0;
        for (int n = 0; n < max_instr; n++) begin
            ins = rom[pc];
            op  = ins[15:12];
            r = '0; r.busy = 1'b1; r.i_addr = 8'(pc);
            exp_q.push_back(r);
            r = '0; r.busy = 1'b1;
            exp_q.push_back(r);
            pc = (pc + 1) % 256;
            if (op == 4'd1) begin
                r = '0; r.busy = 1'b1; r.d_addr = ins[7:0]; r.rf_s = 1'b1;
                exp_q.push_back(r);
                r.w_en = 1'b1; r.w_addr = ins[11:8];
                exp_q.push_back(r);
            end else if (op == 4'd2) begin
                r = '0; r.busy = 1'b1; r.d_wr = 1'b1; r.d_addr = ins[7:0]; r.a_addr = ins[11:8];
                exp_q.push_back(r);
            end else if (op == 4'd3) begin
                r = '0; r.halted = 1'b1;
                exp_q.push_back(r);
                break;
            end else if (op >= 4'd8) begin
                r = '0; r.busy = 1'b1; r.w_en = 1'b1; r.alu_sel = op - 4'd8;
                r.w_addr = ins[11:8]; r.a_addr = ins[7:4]; r.b_addr = ins[3:0];
                exp_q.push_back(r);
            end
        end
    endtask

    // Pulses start, then checks each cycle against the model while toggling start randomly
    // (the machine is busy on every edge after the first, so those pulses must be ignored).
    task automatic run_trace(input string tag, output int halt_cycle);
        halt_cycle = 0;
        start = 1'b1;
        for (int i = 0; i < exp_q.size(); i++) begin
            step();
            check_out($sformatf("%s_cyc%0d", tag, i), obs, exp_q[i]);
            if (halted && halt_cycle == 0) halt_cycle = i + 1;
            start = (i < exp_q.size() - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
        end
        start = 1'b0;
    endtask

    task automatic random_program(input int len);
        int cls;
        for (int i = 0; i < 256; i++) rom[i] = 16'h3000;
        for (int i = 0; i < len; i++) begin
            cls = $urandom_range(0, 5);
            rom[i][11:0] = 12'($urandom);
            case (cls)
                0: rom[i][15:12] = 4'h0;
                1: rom[i][15:12] = 4'h1;
                2: rom[i][15:12] = 4'h2;
                3: rom[i][15:12] = 4'(4 + $urandom_range(0, 3));
                default: rom[i][15:12] = 4'(8 + $urandom_range(0, 7));
            endcase
        end
    endtask

    initial begin
        int   hc;
        out_t zero;
        zero = '0;
        for (int i = 0; i < 256; i++) rom[i] = 16'h0000;

        // Reset state, and idling after release without start.
        #2;
        check_out("reset_outputs", obs, zero);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_out($sformatf("idle_wait%0d", i), obs, zero);
        end

        // Directed program LOAD, LOAD, SUB, STORE, HALT.
        rom[0] = 16'h120B;
        rom[1] = 16'h1305;
        rom[2] = 16'h9001;
        rom[3] = 16'h20CD;
        rom[4] = 16'h3000;
        build_trace(16);
        run_trace("prog", hc);
        check_val("prog_halt_cycles", hc, 17);
        for (int i = 0; i < 3; i++) begin
            step();
            check_val("halted_holds", {31'd0, halted}, 1);
        end

        // Restart from HALTED returns to PC 0 and replays the program.
        run_trace("restart", hc);
        check_val("restart_halt_cycles", hc, 17);

        // Randomized programs, each started from HALTED.
        for (int p = 0; p < 6; p++) begin
            random_program(30);
            build_trace(40);
            run_trace($sformatf("rand%0d", p), hc);
            check_val($sformatf("rand%0d_halted", p), {31'd0, halted}, 1);
        end

        // Reset asserted in the middle of a STORE cycle.
        rom[0] = 16'h20CD;
        rom[1] = 16'h3000;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        check_val("store_dwr_before_reset", {31'd0, D_wr}, 1);
        rst_n = 1'b0;
        #1;
        check_out("reset_mid_store", obs, zero);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            check_out($sformatf("post_reset_idle%0d", i), obs, zero);
        end

        // PC wrap: a ROM full of NOP and reserved encodings never halts.
        for (int i = 0; i < 256; i++)
            rom[i] = {($urandom_range(0, 1) != 0) ? 4'h0 : 4'(4 + $urandom_range(0, 3)), 12'($urandom)};
        build_trace(260);
        run_trace("wrap", hc);
        check_val("wrap_no_halt", hc, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
